generation_engine: RTL and testbench
====================================

// Module: generation_engine
// PURPOSE
//   Holds the 8x8 toroidal CGoL board and sequences one generation per step request.
//   In COMPUTE it streams each row, with its wrapped upper and lower neighbours, to the
//   combinational decoder_top and captures row_out into a shadow buffer. In COMMIT it
//   swaps the shadow buffer into the live board. It exposes a row read port that the
//   display controller uses.
// PARAMETERS
//   ROWS   8   board rows; power of two, >= 4
//   COLS   8   row width; must equal decoder_top width
//   GEN_W  16  generation counter width
// PORTS
//   ph1        in   1        single clock; all state updates on rising edge
//   reset      in   1        async, active-high; clears all state
//   load_en    in   1        write load_row into board[load_addr] (IDLE only)
//   load_addr  in   log2R    row index for load
//   load_row   in   COLS     seed row data
//   step       in   1        request one generation (IDLE only)
//   busy       out  1        high in COMPUTE and COMMIT
//   gen_done   out  1        1-cycle pulse in the COMMIT cycle
//   extinct    out  1        last committed board is all zeros
//   gen_count  out  GEN_W    generations committed since reset
//   row_in     out  COLS     board[idx] to decoder_top
//   row_a      out  COLS     board[(idx-1) mod ROWS] to decoder_top
//   row_b      out  COLS     board[(idx+1) mod ROWS] to decoder_top
//   row_out    in   COLS     next-state row from decoder_top (combinational)
//   disp_addr  in   log2R    display read row
//   disp_row   out  COLS     board[disp_addr], combinational from the live board
// BEHAVIOUR
// - Reset (async): board = 0, shadow = 0, state = IDLE, idx = 0, gen_count = 0,
//   extinct = 1, busy = 0, gen_done = 0.
// - FSM:
//   - IDLE: load_en writes board[load_addr] at the edge. If load_en is low and step
//     is high, go to COMPUTE with idx = 0. If load_en and step are high in the same
//     cycle, the load is performed and the step is ignored.
//   - COMPUTE: each cycle shadow[idx] <= row_out. If idx == ROWS-1, go to COMMIT;
//     otherwise idx++. Lasts exactly ROWS cycles.
//   - COMMIT: board <= shadow; gen_count++ (wraps at 2^GEN_W); extinct <= (shadow == 0);
//     gen_done = 1; idx <= 0; then IDLE.
// - Latency: step sampled at edge N gives busy high from N+1 to N+ROWS+1. gen_done is
//   high in cycle N+ROWS+1. The new board is visible from N+ROWS+2.
//   Back-to-back generations complete every ROWS+2 cycles.
// - step, or load_en, while busy is ignored (no queueing).
// - Row neighbours wrap toroidally: at idx 0, row_a = board[ROWS-1]; at idx ROWS-1,
//   row_b = board[0]. Column wrap is handled by decoder_top.
// - row_in, row_a and row_b are driven from idx in all states. In IDLE idx = 0.
// - The board is read-only during COMPUTE. disp_row is stable across a generation and
//   changes only at the COMMIT edge or on a load.
// - A load issued during busy is dropped and does not corrupt shadow.
// - Reset during COMPUTE or COMMIT aborts immediately: the partial shadow is discarded
//   and gen_count is not incremented.
// TESTING
//   1. Blinker: load row3 = 8'b0001_1100, others 0; step -> after gen_done, rows 2,3,4 =
//      8'b0000_1000; second step restores row3 = 8'b0001_1100; gen_count = 2.
//   2. Block still life: rows 3,4 = 8'b0001_1000; step x4 -> board unchanged,
//      gen_count = 4, extinct = 0.
//   3. Vertical wrap: row7 = 8'b0000_0111 alone (horizontal blinker on the edge); step ->
//      rows 6,7,0 = 8'b0000_0010; checks row_a/row_b wrap at idx 0 and 7.
//   4. Timing: step at cycle N -> busy high exactly cycles N+1..N+9, gen_done only at N+9;
//      extra step pulses at N+3 produce no second generation.
//   5. Lone cell: single 1 at row0 bit0; step -> board all 0, extinct = 1.
//      Simultaneous load_en + step in IDLE -> load written, busy stays 0.
//   6. Reset asserted mid-COMPUTE (idx = 4) -> same cycle busy = 0, board = 0,
//      gen_count = 0; the next step computes an all-zero board.

Source files
------------

// File: rtl/generation_engine.sv
// generation_engine: sequences one Game-of-Life generation on a toroidal ROWS x COLS board.
//   Latency: step sampled at edge N -> busy N+1..N+ROWS+1, gen_done at N+ROWS+1, new board from N+ROWS+2.
//   Backpressure: none; step and load_en are dropped while busy (no queueing).
// Ports:
//   ph1, reset           clock, async active-high reset
//   load_en/addr/row     seed a board row (IDLE only)
//   step                 request one generation (IDLE only)
//   busy, gen_done       COMPUTE/COMMIT indicator, 1-cycle pulse in COMMIT
//   extinct, gen_count   last committed board empty, generations since reset
//   row_in/row_a/row_b   current row and wrapped upper/lower neighbours to the decoder
//   row_out              next-state row from the combinational decoder
//   disp_addr/disp_row   combinational read port on the live board
module generation_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                    ph1,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic [$clog2(ROWS)-1:0] load_addr,
  input  logic [COLS-1:0]         load_row,
  input  logic                    step,
  output logic                    busy,
  output logic                    gen_done,
  output logic                    extinct,
  output logic [GEN_W-1:0]        gen_count,
  output logic [COLS-1:0]         row_in,
  output logic [COLS-1:0]         row_a,
  output logic [COLS-1:0]         row_b,
  input  logic [COLS-1:0]         row_out,
  input  logic [$clog2(ROWS)-1:0] disp_addr,
  output logic [COLS-1:0]         disp_row
);

  localparam int AW = $clog2(ROWS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  logic [1:0]                 state;
  logic [AW-1:0]              idx;
  logic [ROWS-1:0][COLS-1:0]  board;
  logic [ROWS-1:0][COLS-1:0]  shadow;

  // ROWS is a power of two, so plain AW-bit add/subtract gives the toroidal wrap.
  logic [AW-1:0] idx_up;
  logic [AW-1:0] idx_dn;

  assign idx_up = idx - AW'(1);
  assign idx_dn = idx + AW'(1);

  assign row_in   = board[idx];
  assign row_a    = board[idx_up];
  assign row_b    = board[idx_dn];
  assign disp_row = board[disp_addr];

  assign busy     = (state == S_COMPUTE) || (state == S_COMMIT);
  assign gen_done = (state == S_COMMIT);

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      board     <= '0;
      shadow    <= '0;
      gen_count <= '0;
      extinct   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          // A load wins over a simultaneous step.
          if (load_en) begin
            board[load_addr] <= load_row;
          end else if (step) begin
            state <= S_COMPUTE;
            idx   <= '0;
          end
        end
        S_COMPUTE: begin
          // The live board stays frozen here, so every row sees old neighbours.
          shadow[idx] <= row_out;
          if (idx == AW'(ROWS - 1)) begin
            state <= S_COMMIT;
          end else begin
            idx <= idx_dn;
          end
        end
        S_COMMIT: begin
          board     <= shadow;
          gen_count <= gen_count + GEN_W'(1);
          extinct   <= (shadow == '0);
          idx       <= '0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generation_engine.sv
// tb_generation_engine: directed scenarios plus randomized boards for generation_engine.
//   A behavioural decoder stub closes the row_out loop; a whole-board torus model predicts results.
//   Random load/step noise is injected while busy and must have no effect.
module tb_generation_engine;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int GEN_W = 16;

  logic        ph1 = 1'b0;
  logic        reset;
  logic        load_en;
  logic [2:0]  load_addr;
  logic [7:0]  load_row;
  logic        step;
  logic        busy;
  logic        gen_done;
  logic        extinct;
  logic [15:0] gen_count;
  logic [7:0]  row_in;
  logic [7:0]  row_a;
  logic [7:0]  row_b;
  logic [7:0]  row_out;
  logic [2:0]  disp_addr;
  logic [7:0]  disp_row;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [7:0] mb [ROWS];
  int         m_gen;
  logic       m_ext;

  generation_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
    .ph1       (ph1),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_row  (load_row),
    .step      (step),
    .busy      (busy),
    .gen_done  (gen_done),
    .extinct   (extinct),
    .gen_count (gen_count),
    .row_in    (row_in),
    .row_a     (row_a),
    .row_b     (row_b),
    .row_out   (row_out),
    .disp_addr (disp_addr),
    .disp_row  (disp_row)
  );

  always #10 ph1 = ~ph1;

  // Decoder stub: one row's next state with column wrap.
  function automatic logic [7:0] life_row(input logic [7:0] a, input logic [7:0] m,
                                          input logic [7:0] b);
    logic [7:0] r;
    int n;
    int cc;
    r = '0;
    for (int c = 0; c < COLS; c++) begin
      n = 0;
      for (int d = -1; d <= 1; d++) begin
        cc = (c + d + COLS) % COLS;
        n += int'(a[cc]) + int'(b[cc]);
        if (d != 0) n += int'(m[cc]);
      end
      r[c] = (n == 3) || (m[c] && n == 2);
    end
    return r;
  endfunction

  always_comb row_out = life_row(row_a, row_in, row_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  // Whole-board generation on the torus, cell by cell.
  task automatic model_step();
    logic [7:0] nb [ROWS];
    int n;
    logic any;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              n += int'(mb[(r + dr + ROWS) % ROWS][(c + dc + COLS) % COLS]);
        nb[r][c] = (n == 3) || (mb[r][c] && n == 2);
      end
    end
    any = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      mb[r] = nb[r];
      if (nb[r] != 8'h00) any = 1'b1;
    end
    m_gen++;
    m_ext = !any;
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) mb[r] = 8'h00;
    m_gen = 0;
    m_ext = 1'b1;
  endtask

  task automatic check_board(input string tag);
    for (int r = 0; r < ROWS; r++) begin
      disp_addr = 3'(r);
      #1;
      check($sformatf("%s row%0d", tag, r), 32'(disp_row), 32'(mb[r]));
    end
  endtask

  task automatic row_is(input string tag, input int r, input logic [7:0] exp);
    disp_addr = 3'(r);
    #1;
    check(tag, 32'(disp_row), 32'(exp));
  endtask

  task automatic check_status(input string tag);
    check({tag, " gen_count"}, 32'(gen_count), 32'(m_gen & 32'hFFFF));
    check({tag, " extinct"}, 32'(extinct), 32'(m_ext));
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  task automatic load(input int a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = 3'(a);
    load_row  = d;
    tick();
    load_en = 1'b0;
    mb[a]   = d;
  endtask

  task automatic load_board(input logic [7:0] d [ROWS]);
    for (int r = 0; r < ROWS; r++) load(r, d[r]);
  endtask

  task automatic clear_board();
    for (int r = 0; r < ROWS; r++) load(r, 8'h00);
  endtask

  // One generation; with noise, random loads/steps are thrown at the busy DUT.
  task automatic do_step(input string tag, input bit noise);
    int cnt;
    step = 1'b1;
    tick();
    step = 1'b0;
    cnt  = 0;
    while (!gen_done && cnt < 20) begin
      if (noise) begin
        load_en   = 1'($urandom_range(0, 1));
        load_addr = 3'($urandom);
        load_row  = 8'($urandom);
        step      = 1'($urandom_range(0, 1));
      end
      tick();
      cnt++;
    end
    load_en = 1'b0;
    step    = 1'b0;
    check({tag, " gen_done seen"}, 32'(gen_done), 32'd1);
    model_step();
    tick();
    check_board(tag);
    check_status(tag);
  endtask

  logic [7:0] rb [ROWS];
  int         nsteps;

  initial begin
    reset     = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_row  = '0;
    step      = 1'b0;
    disp_addr = '0;
    model_reset();
    #5;
    check("reset busy", 32'(busy), 32'd0);
    check("reset gen_done", 32'(gen_done), 32'd0);
    check("reset extinct", 32'(extinct), 32'd1);
    check("reset gen_count", 32'(gen_count), 32'd0);
    check("reset row_in", 32'(row_in), 32'd0);
    #10;
    reset = 1'b0;
    tick();
    check_board("reset board");

    // 1. blinker oscillates
    load(3, 8'h1C);
    do_step("blinker1", 1'b0);
    row_is("blinker v r2", 2, 8'h08);
    row_is("blinker v r3", 3, 8'h08);
    row_is("blinker v r4", 4, 8'h08);
    do_step("blinker2", 1'b0);
    row_is("blinker h r3", 3, 8'h1C);
    check("blinker gen_count", 32'(gen_count), 32'd2);

    // 2. block still life
    clear_board();
    load(3, 8'h18);
    load(4, 8'h18);
    for (int i = 0; i < 4; i++) do_step($sformatf("block%0d", i), 1'b0);
    row_is("block r3", 3, 8'h18);
    row_is("block r4", 4, 8'h18);
    check("block gen_count", 32'(gen_count), 32'd6);
    check("block extinct", 32'(extinct), 32'd0);

    // 3. vertical wrap: blinker on row 7
    clear_board();
    load(7, 8'h07);
    check("idle row_in idx0", 32'(row_in), 32'h00);
    check("idle row_a wrap", 32'(row_a), 32'h07);
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("idx7 row_in", 32'(row_in), 32'h07);
    check("idx7 row_b wrap", 32'(row_b), 32'h00);
    check("idx7 busy", 32'(busy), 32'd1);
    tick();
    check("wrap gen_done", 32'(gen_done), 32'd1);
    model_step();
    tick();
    check_board("wrap");
    check_status("wrap");
    row_is("wrap r6", 6, 8'h02);
    row_is("wrap r7", 7, 8'h02);
    row_is("wrap r0", 0, 8'h02);

    // 4. timing with an extra step pulse mid-generation
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("timing busy N+%0d", k), 32'(busy), 32'd1);
      check($sformatf("timing gen_done N+%0d", k), 32'(gen_done), 32'(k == 9));
      step = (k == 2);
      tick();
    end
    step = 1'b0;
    model_step();
    check("timing busy N+10", 32'(busy), 32'd0);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("timing idle %0d", k), 32'(busy | gen_done), 32'd0);
      tick();
    end
    check_board("timing");
    check_status("timing");

    // 5. lone cell dies; simultaneous load+step
    clear_board();
    load(0, 8'h01);
    do_step("lone", 1'b0);
    check("lone extinct", 32'(extinct), 32'd1);
    load_en   = 1'b1;
    step      = 1'b1;
    load_addr = 3'd5;
    load_row  = 8'hA5;
    tick();
    load_en = 1'b0;
    step    = 1'b0;
    mb[5]   = 8'hA5;
    check("load+step busy", 32'(busy), 32'd0);
    tick();
    check("load+step busy later", 32'(busy), 32'd0);
    check_board("load+step");

    // randomized boards with busy-time noise
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < ROWS; r++) rb[r] = 8'($urandom) & 8'($urandom | $urandom);
      load_board(rb);
      nsteps = $urandom_range(1, 3);
      for (int s = 0; s < nsteps; s++) do_step($sformatf("rand%0d_%0d", t, s), 1'b1);
    end

    // 6. reset mid-compute at idx 4
    for (int r = 0; r < ROWS; r++) rb[r] = 8'($urandom) | 8'h01;
    load_board(rb);
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("abort idx4 row_in", 32'(row_in), 32'(mb[4]));
    reset = 1'b1;
    #1;
    model_reset();
    check("abort busy", 32'(busy), 32'd0);
    check("abort gen_count", 32'(gen_count), 32'd0);
    check_board("abort");
    #3;
    reset = 1'b0;
    tick();
    do_step("post-abort", 1'b0);
    check("post-abort gen_count", 32'(gen_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
